// File: rtl/instr_queue.sv
// instr_queue: circular fetch-to-decode FIFO moving up to two entries in and
// two entries out per cycle, with predicted-branch entries held to slot [1].
// Ports: clk, resetn (async, active-low), flush (drop everything),
//        in_valid/in_data/in_ready (fetch pair, [1] older),
//        out_data/out_ready (issue pair, [1] older), count (occupancy).
// Option: define IQ_BYPASS_EN for same-cycle bypass into an empty queue.

package instr_queue_pkg;
   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] instr;
      logic        pre_b;
      logic [31:0] pre_pc;
   } fetch_data_t;
endpackage

module instr_queue
   import instr_queue_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   flush,
   input  logic                   in_valid,
   input  fetch_data_t [1:0]      in_data,
   output logic                   in_ready,
   output fetch_data_t [1:0]      out_data,
   input  logic                   out_ready,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   fetch_data_t   mem_q [DEPTH];
   logic [AW-1:0] head_q, head_d, tail_q, tail_d;
   logic [AW-1:0] head_p1, tail_p1;
   logic [AW:0]   count_q, count_d;

   fetch_data_t   c1, c0;
   fetch_data_t   q1, q0;
   fetch_data_t   wr_a, wr_b;
   logic [1:0]    n_c, n_wr, n_deq;
   logic          enq;
`ifdef IQ_BYPASS_EN
   logic          bypass;
`endif

   assign head_p1  = head_q + AW'(1);
   assign tail_p1  = tail_q + AW'(1);
   assign in_ready = (DEPTH_C - count_q) >= (AW+1)'(2);
   assign count    = count_q;
   assign enq      = in_valid & in_ready & ~flush;

   always_comb begin
      // Compact the fetch pair so present elements sit oldest-first.
      c1 = '0;
      c0 = '0;
      if (in_data[1].valid) begin
         c1 = in_data[1];
         if (in_data[0].valid) c0 = in_data[0];
      end else if (in_data[0].valid) begin
         c1 = in_data[0];
      end
      n_c = {1'b0, in_data[1].valid} + {1'b0, in_data[0].valid};

      q1 = '0;
      q0 = '0;
      if (count_q != '0) begin
         q1       = mem_q[head_q];
         q1.valid = 1'b1;
      end
      // A predicted branch never issues in the younger slot.
      if (count_q >= (AW+1)'(2) && !mem_q[head_p1].pre_b) begin
         q0        = mem_q[head_p1];
         q0.valid  = 1'b1;
         q0.pre_b  = 1'b0;
         q0.pre_pc = '0;
      end

      out_data[1] = q1;
      out_data[0] = q0;
      wr_a        = c1;
      wr_b        = c0;
      n_wr        = enq ? n_c : 2'd0;
      n_deq       = out_ready ? ({1'b0, q1.valid} + {1'b0, q0.valid}) : 2'd0;

`ifdef IQ_BYPASS_EN
      bypass = resetn & in_valid & out_ready & ~flush & (count_q == '0);
      if (bypass) begin
         out_data[1] = c1;
         out_data[0] = '0;
         n_deq       = 2'd0;
         n_wr        = 2'd0;
         if (c0.valid && !c0.pre_b) begin
            out_data[0]        = c0;
            out_data[0].pre_pc = '0;
         end else if (c0.valid) begin
            // Held-back branch goes into the queue for next cycle's slot [1].
            wr_a = c0;
            n_wr = 2'd1;
         end
      end
`endif

      count_d = count_q + (AW+1)'(n_wr) - (AW+1)'(n_deq);
      head_d  = head_q + AW'(n_deq);
      tail_d  = tail_q + AW'(n_wr);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else if (flush) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (n_wr != 2'd0) mem_q[tail_q]  <= wr_a;
      if (n_wr == 2'd2) mem_q[tail_p1] <= wr_b;
   end

endmodule

// File: tb/tb_instr_queue.sv
// tb_instr_queue: directed stimulus with a scoreboard of expected issue order
// and a negedge monitor comparing every element decode accepts.

module tb_instr_queue;
   import instr_queue_pkg::*;

   localparam int DEPTH = 8;

   typedef struct packed {
      logic [31:0] pc;
      logic        pre_b;
   } exp_t;

   logic              clk = 1'b0;
   logic              resetn;
   logic              flush;
   logic              in_valid;
   fetch_data_t [1:0] in_data;
   logic              in_ready;
   fetch_data_t [1:0] out_data;
   logic              out_ready;
   logic [3:0]        count;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   instr_queue #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_ready (out_ready),
      .count     (count)
   );

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic fetch_data_t mk(input logic [31:0] pc, input logic v,
                                      input logic pb, input logic [31:0] ppc);
      fetch_data_t d;
      d.valid  = v;
      d.pc     = pc;
      d.instr  = ~pc;
      d.pre_b  = pb;
      d.pre_pc = ppc;
      return d;
   endfunction

   function automatic void push(input fetch_data_t d);
      exp_t e;
      e.pc    = d.pc;
      e.pre_b = d.pre_b;
      exp_q.push_back(e);
   endfunction

   task automatic pop_cmp(input fetch_data_t d, input string name);
      exp_t e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: unexpected pc %0h, expected none", name, d.pc);
      end else begin
         e = exp_q.pop_front();
         chk(name, 64'({d.pc, d.pre_b}), 64'({e.pc, e.pre_b}));
      end
   endtask

   always @(negedge clk) begin
      if (resetn === 1'b1) begin
         chk("slot0_pre_zero", 64'({out_data[0].pre_b, out_data[0].pre_pc}), 0);
         if (out_ready) begin
            if (out_data[1].valid) pop_cmp(out_data[1], "issue_slot1");
            if (out_data[0].valid) pop_cmp(out_data[0], "issue_slot0");
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      tick();
      out_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (count == 0) break;
      end
      out_ready = 1'b0;
      chk("drain_count", 64'(count), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  idx;
      bit  acc;
      resetn    = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_data   = '0;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_count", 64'(count), 0);
      chk("rst_in_ready", 64'(in_ready), 1);
      chk("rst_out_zero", 64'(out_data == '0), 1);
      tick();
      resetn = 1'b1;

      // first pair, one-cycle latency
      in_data[1] = mk(32'hbfc00000, 1, 0, 0);
      in_data[0] = mk(32'hbfc00004, 1, 0, 0);
      in_valid   = 1'b1;
      push(in_data[1]);
      push(in_data[0]);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk("first_count", 64'(count), 2);
      chk("first_pc1", 64'(out_data[1].pc), 64'h bfc00000);
      chk("first_pc0", 64'(out_data[0].pc), 64'h bfc00004);
      chk("first_valid", 64'({out_data[1].valid, out_data[0].valid}), 3);
      drain();

      // fill to full, fifth pair refused
      for (int k = 0; k < 5; k++) begin
         in_data[1] = mk(32'h1000 + 32'(8 * k), 1, 0, 0);
         in_data[0] = mk(32'h1004 + 32'(8 * k), 1, 0, 0);
         in_valid   = 1'b1;
         if (k < 4) begin
            push(in_data[1]);
            push(in_data[0]);
         end
         tick();
      end
      in_valid = 1'b0;
      @(negedge clk);
      chk("full_count", 64'(count), 8);
      chk("full_in_ready", 64'(in_ready), 0);
      drain();

      // younger entry is a predicted branch
      in_data[1] = mk(32'h2000, 1, 0, 0);
      in_data[0] = mk(32'h2004, 1, 1, 32'h3000);
      in_valid   = 1'b1;
      push(in_data[1]);
      push(in_data[0]);
      tick();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("br_valid", 64'({out_data[1].valid, out_data[0].valid}), 2);
      chk("br_pc1", 64'(out_data[1].pc), 64'h2000);
      tick();
      out_ready = 1'b0;
      @(negedge clk);
      chk("br_count", 64'(count), 1);
      chk("br_next_pc1", 64'(out_data[1].pc), 64'h2004);
      chk("br_next_preb", 64'(out_data[1].pre_b), 1);
      chk("br_next_prepc", 64'(out_data[1].pre_pc), 64'h3000);
      drain();

      // only element [0] present
      in_data[1] = mk(32'h6800, 0, 0, 0);
      in_data[0] = mk(32'h6804, 1, 0, 0);
      in_valid   = 1'b1;
      push(in_data[0]);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk("solo_count", 64'(count), 1);
      chk("solo_pc1", 64'(out_data[1].pc), 64'h6804);
      drain();

      // count=5 then flush with incoming pair
      in_valid   = 1'b1;
      in_data[1] = mk(32'h6000, 1, 0, 0);
      in_data[0] = mk(32'h6004, 1, 0, 0);
      tick();
      in_data[1] = mk(32'h6008, 1, 0, 0);
      in_data[0] = mk(32'h600c, 1, 0, 0);
      tick();
      in_data[1] = mk(32'h0, 0, 0, 0);
      in_data[0] = mk(32'h6010, 1, 0, 0);
      tick();
      in_data[1] = mk(32'h0, 0, 0, 0);
      in_data[0] = mk(32'h0, 0, 0, 0);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk("pre_flush_count", 64'(count), 5);
      chk("pre_flush_pc1", 64'(out_data[1].pc), 64'h6000);
      tick();
      flush      = 1'b1;
      in_valid   = 1'b1;
      in_data[1] = mk(32'h7000, 1, 0, 0);
      in_data[0] = mk(32'h7004, 1, 0, 0);
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("flush_count", 64'(count), 0);
      chk("flush_out_zero", 64'(out_data == '0), 1);
      chk("flush_in_ready", 64'(in_ready), 1);
      tick();

      // 20 pairs streaming across wrap-around
      idx = 0;
      for (int cyc = 0; cyc < 300 && idx < 20; cyc++) begin
         in_data[1] = mk(32'h4000 + 32'(8 * idx), 1, 0, 0);
         in_data[0] = mk(32'h4004 + 32'(8 * idx), 1, 0, 0);
         in_valid   = 1'b1;
         out_ready  = (cyc % 2) == 1;
         acc        = in_ready;
         if (acc) begin
            push(in_data[1]);
            push(in_data[0]);
         end
         tick();
         if (acc) idx++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk("stream_sent", 64'(idx), 20);
      drain();

      // reset in the middle of operation
      in_data[1] = mk(32'h8000, 1, 0, 0);
      in_data[0] = mk(32'h8004, 1, 0, 0);
      in_valid   = 1'b1;
      tick();
      in_valid = 1'b0;
      resetn   = 1'b0;
      #1;
      chk("midrst_count", 64'(count), 0);
      chk("midrst_out_zero", 64'(out_data == '0), 1);
      tick();
      resetn = 1'b1;
      tick();

      // empty queue, decode ready
      in_data[1] = mk(32'h5000, 1, 0, 0);
      in_data[0] = mk(32'h5004, 1, 0, 0);
      in_valid   = 1'b1;
      out_ready  = 1'b1;
      push(in_data[1]);
      push(in_data[0]);
      @(negedge clk);
`ifdef IQ_BYPASS_EN
      chk("byp_valid", 64'(out_data[1].valid), 1);
      chk("byp_pc1", 64'(out_data[1].pc), 64'h5000);
      chk("byp_count", 64'(count), 0);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk("byp_after_count", 64'(count), 0);
`else
      chk("nobyp_valid", 64'(out_data[1].valid), 0);
      chk("nobyp_count", 64'(count), 0);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk("nobyp_late_valid", 64'(out_data[1].valid), 1);
      chk("nobyp_late_pc1", 64'(out_data[1].pc), 64'h5000);
      chk("nobyp_late_count", 64'(count), 2);
`endif
      drain();

      chk("scoreboard_empty", 64'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_queue.md
INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 SHALL provide parameter DEPTH, default 8, number of queue entries (power of two, >= 4).
REQ-002 SHALL provide ports: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL provide ports: resetn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide ports: flush  input  1  pipeline redirect; discard all queued and incoming entries.
REQ-005 SHALL provide ports: in_valid  input  1  fetch pair offered.
REQ-006 SHALL provide ports: in_data  input  2 x fetch_data_t  fetch pair; element [1] older; per-element .valid marks presence.
REQ-007 SHALL provide ports: in_ready  output  1  queue can accept a full pair.
REQ-008 SHALL provide ports: out_data  output  2 x fetch_data_t  issue pair to decode; element [1] older.
REQ-009 SHALL provide ports: out_ready  input  1  decode accepts every element presented with .valid=1.
REQ-010 SHALL provide ports: count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-011 SHALL be a circular FIFO with head/tail pointers wrapping modulo DEPTH.
REQ-012 SHALL drive in_ready = 1 iff DEPTH - count >= 2, from registered state only.
REQ-013 SHALL enqueue when in_valid & in_ready & ~flush: write present elements in order [1] then [0], compacted; a pair with only [0] valid writes one entry; a pair with no valid element writes none.
REQ-014 SHALL present out_data[1] = head entry with .valid=1 when count >= 1, else all-zero.
REQ-015 SHALL present out_data[0] = entry head+1 with .valid=1 when count >= 2 and that entry's pre_b = 0, else all-zero.
REQ-016 SHALL hold an entry with pre_b = 1 back from slot [0] so it issues next time in slot [1].
REQ-017 SHALL force out_data[0].pre_b and out_data[0].pre_pc to zero at all times.
REQ-018 SHALL advance head on out_ready by the number of valid out_data elements (0, 1 or 2).
REQ-019 SHALL update count = count + n_in - n_out when enqueue and dequeue occur in the same cycle.
REQ-020 SHALL, on flush = 1, set count, head and tail to 0 on the next edge, ignoring same-cycle enqueue and dequeue.
REQ-021 SHALL have a one-cycle enqueue-to-output latency when the bypass feature is absent.
REQ-022 SHALL preserve program order across pointer wrap-around.

Reset
REQ-023 SHALL, while resetn = 0, hold count = 0, head = tail = 0, in_ready = 1 and both out_data elements all-zero.
REQ-024 SHALL leave storage array contents unreset.
REQ-025 SHALL, on reset asserted mid-operation, drop all entries immediately.

Configuration
REQ-026 SHALL compile the same-cycle bypass in only when macro IQ_BYPASS_EN is defined.
REQ-027 With IQ_BYPASS_EN defined, SHALL route in_data straight to out_data and write nothing when count = 0 and in_valid & out_ready & ~flush.
REQ-028 With IQ_BYPASS_EN defined, SHALL still apply REQ-015..017 to bypassed elements.
REQ-029 With IQ_BYPASS_EN defined, SHALL write any element held back by REQ-016 into the queue.
REQ-030 Without IQ_BYPASS_EN, SHALL present outputs from queue state only.

Verification
REQ-031 SHALL cover: after reset, enqueue pair pc 0xbfc00000/0xbfc00004 -> next cycle out_data[1].pc=0xbfc00000, out_data[0].pc=0xbfc00004, both valid, count=2.
REQ-032 SHALL cover: out_ready=0, four full pairs offered -> count=8, in_ready=0; fifth pair not written.
REQ-033 SHALL cover: queued pair where younger entry has pre_b=1 and out_ready=1 -> only slot [1] valid, count decrements by 1; next cycle that entry is in slot [1] with pre_b=1.
REQ-034 SHALL cover: flush=1 with in_valid=1 and count=5 -> next cycle count=0 and both outputs invalid.
REQ-035 SHALL cover: 20 pairs with incrementing pc and out_ready toggling each cycle -> issued pc sequence strictly increasing by 4 across wrap-around.
REQ-036 SHALL cover: empty queue, pair offered with out_ready=1 -> with IQ_BYPASS_EN, same-cycle output and count stays 0; without it, output one cycle later.
